// File: rtl/t64_pkg.sv
// Shared Twin-64 types and widths used by the fetch front end and, later, decode.
package t64_pkg;

    localparam int T64_ADDR_W  = 32;
    localparam int T64_WORD_W  = 64;
    localparam int T64_INSTR_W = 32;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [T64_ADDR_W-1:0]  pc;
        logic [T64_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clears the byte offset so an address points at the start of its 64-bit word.
    function automatic logic [T64_ADDR_W-1:0] word_align(input logic [T64_ADDR_W-1:0] addr);
        return {addr[T64_ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/t64_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and decode.
//
// Handshake: decode takes the head entry on every rising edge where
// inst_valid && inst_ready are both 1. inst_valid never depends on
// inst_ready, and inst/inst_pc are held steady while inst_valid=1 and
// inst_ready=0. The memory side has no handshake: a read issued with
// mem_read_en=1 is answered with mem_read_data on the following cycle.
interface t64_fetch_unit_if;
    import t64_pkg::*;

    logic [T64_ADDR_W-1:0]  mem_addr;
    logic                   mem_read_en;
    logic [T64_WORD_W-1:0]  mem_read_data;
    logic                   redirect_valid;
    logic [T64_ADDR_W-1:0]  redirect_pc;
    logic                   inst_valid;
    logic [T64_INSTR_W-1:0] inst;
    logic [T64_ADDR_W-1:0]  inst_pc;
    logic                   inst_ready;

    // Fetch unit side.
    modport master (
        output mem_addr, mem_read_en, inst_valid, inst, inst_pc,
        input  mem_read_data, redirect_valid, redirect_pc, inst_ready
    );

    // Memory / decode / redirect-source side.
    modport slave (
        input  mem_addr, mem_read_en, inst_valid, inst, inst_pc,
        output mem_read_data, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/t64_fetch_queue.sv
// Circular FIFO of fetch entries: up to two pushes and one pop per cycle,
// synchronous flush, and an occupancy count for credit decisions upstream.
module t64_fetch_queue
    import t64_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push0_valid,
    input  fetch_entry_t           push0_data,
    input  logic                   push1_valid,
    input  fetch_entry_t           push1_data,
    input  logic                   pop,
    output logic                   head_valid,
    output fetch_entry_t           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [1:0]       n_push;
    logic             do_pop;

    // Second push slot is only meaningful together with the first one.
    always_comb begin
        n_push = {1'b0, push0_valid} + {1'b0, push0_valid & push1_valid};
        do_pop = pop && (count != '0);
    end

    // Pointer and occupancy update; flush wins over any push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            count  <= count + CNT_W'(n_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents beyond count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (!flush && push0_valid) begin
            store[wr_ptr] <= push0_data;
            if (push1_valid) begin
                store[wr_ptr + PTR_W'(1)] <= push1_data;
            end
        end
    end

    // Head is read straight from storage and forced to zero when empty.
    always_comb begin
        head_valid = (count != '0);
        head_data  = head_valid ? store[rd_ptr] : '0;
    end

    // Upstream credit accounting must never let the queue overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !flush |-> (int'(count) + int'(n_push) - int'(do_pop)) <= DEPTH);

endmodule

// File: rtl/t64_fetch_unit.sv
// Twin-64 instruction fetch: issues 64-bit reads under a credit rule, splits
// each returned word into two instructions and queues them for decode.
module t64_fetch_unit
    import t64_pkg::*;
#(
    parameter int                    QUEUE_DEPTH = 8,
    parameter logic [T64_ADDR_W-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    t64_fetch_unit_if.master bus
);

    localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int CRED_W = CNT_W + 2;

    logic [T64_ADDR_W-1:0] fetch_pc;
    logic                  skip_first;
    // Issue stage: request presented to memory this cycle.
    logic                  issue_v;
    logic                  issue_skip;
    logic [T64_ADDR_W-1:0] mem_addr_q;
    // Memory stage: mem_read_data holds this request's word this cycle.
    logic                  mem_v;
    logic                  mem_skip;
    logic [T64_ADDR_W-1:0] mem_pc;

    logic [1:0]            inflight;
    logic [CRED_W-1:0]     credit_need;
    logic                  credit_ok;
    logic [CNT_W-1:0]      q_count;
    logic                  push0_valid;
    logic                  push1_valid;
    fetch_entry_t          push0_data;
    fetch_entry_t          push1_data;
    fetch_entry_t          head_entry;
    logic                  head_valid;
    logic                  unused_redirect_lsbs;

    // The two low PC bits only select bytes within an instruction.
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // Reserve two slots per outstanding request plus two for the new one.
    always_comb begin
        inflight    = {1'b0, issue_v} + {1'b0, mem_v};
        credit_need = CRED_W'(q_count) + CRED_W'({inflight, 1'b0}) + CRED_W'(2);
        credit_ok   = (credit_need <= CRED_W'(QUEUE_DEPTH)) && !bus.redirect_valid;
    end

    // Fetch pointer, redirect handling and the two-stage request tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            skip_first <= 1'b0;
            issue_v    <= 1'b0;
            issue_skip <= 1'b0;
            mem_addr_q <= RESET_PC;
            mem_v      <= 1'b0;
            mem_skip   <= 1'b0;
            mem_pc     <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc   <= word_align(bus.redirect_pc);
            skip_first <= bus.redirect_pc[2];
            issue_v    <= 1'b0;
            issue_skip <= 1'b0;
            mem_v      <= 1'b0;
            mem_skip   <= 1'b0;
        end else begin
            mem_v    <= issue_v;
            mem_skip <= issue_skip;
            mem_pc   <= mem_addr_q;
            issue_v  <= credit_ok;
            if (credit_ok) begin
                mem_addr_q <= fetch_pc;
                fetch_pc   <= fetch_pc + 32'd8;
                issue_skip <= skip_first;
                skip_first <= 1'b0;
            end
        end
    end

    // Split the returned word: upper half is the lower address; a skipped
    // request delivers only its second instruction.
    always_comb begin
        push0_valid      = mem_v;
        push1_valid      = mem_v && !mem_skip;
        push1_data.pc    = mem_pc + 32'd4;
        push1_data.instr = bus.mem_read_data[31:0];
        if (mem_skip) begin
            push0_data = push1_data;
        end else begin
            push0_data.pc    = mem_pc;
            push0_data.instr = bus.mem_read_data[63:32];
        end
    end

    t64_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush       (bus.redirect_valid),
        .push0_valid (push0_valid),
        .push0_data  (push0_data),
        .push1_valid (push1_valid),
        .push1_data  (push1_data),
        .pop         (bus.inst_ready),
        .head_valid  (head_valid),
        .head_data   (head_entry),
        .count       (q_count)
    );

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_read_en = issue_v;
    assign bus.inst_valid  = head_valid;
    assign bus.inst        = head_entry.instr;
    assign bus.inst_pc     = head_entry.pc;

endmodule
